packet_scheduler: RTL and testbench
===================================

// Module: packet_scheduler
// PURPOSE
//  Picks which HDMI data-island packet to transmit in each packet slot. There are
//  NUM_SOURCES packet generators: ACR, audio sample, AVI/audio/SPD InfoFrames.
//  Streaming sources (audio) win by fixed priority. Once-per-frame InfoFrames
//  share the remaining slots round-robin. Sits between the packet generators and
//  packet_assembler; the HDMI top issues packet_slot at each island packet boundary.
// PARAMETERS
//  NUM_SOURCES   5          number of packet sources; index 0 has highest fixed priority
//  FRAME_MASK    5'b11100   bit i=1: source i is sent once per frame; bit i=0: streaming (req-driven)
// PORTS
//  clk_pixel      in   1            pixel clock; all logic on rising edge
//  reset          in   1            asynchronous, active-high
//  frame_start    in   1            1-cycle pulse at start of vertical sync
//  req            in   NUM_SOURCES  level request; used only for streaming sources
//  src_header     in   [N][24]      header of each source (hdmi_packet_pkg::header_t)
//  src_sub        in   [N][4][56]   subpackets of each source (hdmi_packet_pkg::sub_t)
//  packet_slot    in   1            1-cycle pulse: choose the packet for the next slot
//  header         out  24           registered header of the chosen packet
//  sub            out  [4][56]      registered subpackets of the chosen packet
//  grant          out  NUM_SOURCES  one-hot 1-cycle pulse naming the source consumed
//  pending        out  NUM_SOURCES  frame sources still owed this frame
//  missed_frame   out  1            sticky: a frame source was still pending at frame_start
// BEHAVIOUR
//  - Reset values: header=0, sub=all 0 (null packet), grant=0, pending=0, missed_frame=0.
//    RR pointer resets to the lowest set bit of FRAME_MASK.
//  - Reset asserted mid-packet: outputs drop to the null packet immediately. Nothing is retained.
//  - pending[i] (FRAME_MASK[i]=1):
//    - set on frame_start;
//    - cleared on the cycle grant[i] is asserted;
//    - if frame_start and grant[i] coincide, set wins.
//  - Eligibility for a slot:
//    - streaming source i: req[i]=1;
//    - frame source i: pending[i]=1.
//  - On packet_slot, at the same clock edge:
//    1. If any streaming source is eligible, the lowest index among them wins.
//    2. Otherwise the first eligible frame source at or after the RR pointer (wrapping) wins.
//       The pointer then moves to the next frame source after the winner (wrapping).
//    3. Otherwise the null packet is chosen (header 24'h000000, subs 0) and grant stays 0.
//  - Output timing and hold:
//    - header and sub take the winner's src_header/src_sub; latency 1 cycle after packet_slot.
//    - header/sub hold until the next packet_slot or reset. Sources may change their
//      inputs after their grant without corrupting a packet in flight.
//    - grant is asserted in the same cycle that header/sub update. A source must treat
//      grant as consumption (pop its FIFO entry or advance its state).
//  - Without packet_slot, header/sub/grant are stable and the RR pointer does not move.
//  - missed_frame: set when frame_start arrives while any pending bit is 1; cleared only
//    by reset.
//  - Simultaneous frame_start and packet_slot: arbitration uses the pre-update pending.
//    The newly set bits are eligible from the next slot.
//  - req is sampled only on packet_slot cycles. Streaming starvation of frame sources is
//    allowed and is shown by missed_frame.
// STRUCTURE
//  - hdmi_packet_pkg holds:
//    - typedef header_t = logic [23:0];
//    - typedef sub_t = logic [3:0][55:0];
//    - localparam NULL_HEADER;
//    - packet type codes: ACR=8'h01, AUDIO_SAMPLE=8'h02, AVI=8'h82, SPD=8'h83, AUDIO_IF=8'h84.
//  - One sub-module: round_robin_arbiter #(N) with inputs elig, ptr and outputs onehot,
//    next_ptr. It is combinational; the pointer register lives in packet_scheduler.
//  - The fixed-priority path, pending/missed registers and the output mux/registers
//    stay inline.
// TESTING
//  1. Reset held 3 cycles, then 5 packet_slot pulses with no req/frame_start
//     -> header=0, sub=0, grant=0 every slot.
//  2. frame_start, then 3 slots, default mask -> grant sequence 5'b00100, 5'b01000,
//     5'b10000; pending 5'b11100 -> 5'b11000 -> 5'b10000 -> 0; 4th slot gives null.
//  3. req=5'b00011 held and frame_start; 2 slots -> both grant 5'b00001.
//     Drop req[0] -> next grant 5'b00010; drop req[1] -> next grant 5'b00100.
//  4. frame_start with req[0]=1 held for a full frame, then a 2nd frame_start
//     -> missed_frame=1 and stays 1. pending=5'b11100.
//  5. frame_start on the same cycle as packet_slot while pending=5'b10000
//     -> grant 5'b10000; the next cycle shows pending=5'b11100 (set wins).
//  6. Assert reset one cycle after an AVI grant
//     -> header drops to 0 asynchronously and pending=0. After release, the first
//        frame_start/slot grants 5'b00100.

Source files
------------

// File: rtl/hdmi_packet_pkg.sv
// Shared HDMI data-island packet types, null packet constants and packet type codes.
package hdmi_packet_pkg;

    typedef logic [23:0]       header_t;
    typedef logic [3:0][55:0]  sub_t;

    localparam header_t NULL_HEADER = 24'h000000;
    localparam sub_t    NULL_SUB    = 224'h0;

    localparam logic [7:0] PKT_ACR          = 8'h01;
    localparam logic [7:0] PKT_AUDIO_SAMPLE = 8'h02;
    localparam logic [7:0] PKT_AVI          = 8'h82;
    localparam logic [7:0] PKT_SPD          = 8'h83;
    localparam logic [7:0] PKT_AUDIO_IF     = 8'h84;

    // Index of the lowest set bit of a mask; 0 when the mask is empty.
    function automatic int lowest_set_bit(input logic [31:0] mask);
        int r;
        r = 0;
        for (int i = 31; i >= 0; i--) begin
            r = mask[i] ? i : r;
        end
        return r;
    endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin pick: first eligible index at or after ptr (wrapping),
// and the next MASK position after the winner as the proposed new pointer.
module round_robin_arbiter #(
    parameter int            N    = 5,
    parameter logic [N-1:0]  MASK = {N{1'b1}},
    parameter int            PW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   elig,
    input  logic [PW-1:0]  ptr,
    output logic [N-1:0]   onehot,
    output logic [PW-1:0]  next_ptr
);

    // Rotating search from ptr, then locate the next masked slot after the winner.
    always_comb begin
        int   idx;
        int   win;
        int   j;
        logic found;
        logic hit;
        logic nf;
        logic take;
        onehot   = {N{1'b0}};
        next_ptr = ptr;
        found    = 1'b0;
        win      = 0;
        idx      = 0;
        j        = 0;
        hit      = 1'b0;
        nf       = 1'b0;
        take     = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx         = int'(ptr) + i;
            idx         = (idx >= N) ? idx - N : idx;
            hit         = elig[idx] & ~found;
            onehot[idx] = hit;
            win         = hit ? idx : win;
            found       = found | elig[idx];
        end
        for (int k = 1; k <= N; k++) begin
            j        = win + k;
            j        = (j >= N) ? j - N : j;
            take     = MASK[j] & ~nf & found;
            next_ptr = take ? PW'(j) : next_ptr;
            nf       = nf | MASK[j];
        end
    end

endmodule

// File: rtl/packet_scheduler.sv
// Chooses the HDMI data-island packet for each packet slot: streaming sources by
// fixed priority, once-per-frame InfoFrames round-robin, otherwise the null packet.
module packet_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int                      NUM_SOURCES = 5,
    parameter logic [NUM_SOURCES-1:0]  FRAME_MASK  = 5'b11100
) (
    input  logic                    clk_pixel,
    input  logic                    reset,
    input  logic                    frame_start,
    input  logic [NUM_SOURCES-1:0]  req,
    input  header_t                 src_header [NUM_SOURCES],
    input  sub_t                    src_sub    [NUM_SOURCES],
    input  logic                    packet_slot,
    output header_t                 header,
    output sub_t                    sub,
    output logic [NUM_SOURCES-1:0]  grant,
    output logic [NUM_SOURCES-1:0]  pending,
    output logic                    missed_frame
);

    localparam int             PW        = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam logic [PW-1:0]  RESET_PTR = PW'(lowest_set_bit(32'(FRAME_MASK)));
    localparam logic [NUM_SOURCES-1:0] ONE = {{(NUM_SOURCES-1){1'b0}}, 1'b1};

    logic [NUM_SOURCES-1:0] pending_r;
    logic [PW-1:0]          ptr_r;
    logic                   missed_r;

    logic [NUM_SOURCES-1:0] stream_elig_s;
    logic [NUM_SOURCES-1:0] frame_elig_s;
    logic [NUM_SOURCES-1:0] stream_win_s;
    logic [NUM_SOURCES-1:0] rr_win_s;
    logic [PW-1:0]          rr_next_ptr_s;
    logic [NUM_SOURCES-1:0] win_s;
    logic                   rr_take_s;
    logic [NUM_SOURCES-1:0] pending_next_s;
    header_t                win_hdr_s;
    sub_t                   win_sub_s;

    // Eligibility split: streaming follows req, frame sources follow pending.
    always_comb begin
        stream_elig_s = req & ~FRAME_MASK;
        frame_elig_s  = pending_r & FRAME_MASK;
        // Isolate the lowest set bit: lowest index has highest priority.
        stream_win_s  = stream_elig_s & (~stream_elig_s + ONE);
    end

    round_robin_arbiter #(
        .N    (NUM_SOURCES),
        .MASK (FRAME_MASK),
        .PW   (PW)
    ) u_rr (
        .elig     (frame_elig_s),
        .ptr      (ptr_r),
        .onehot   (rr_win_s),
        .next_ptr (rr_next_ptr_s)
    );

    // Final winner, pending update (frame_start set beats grant clear) and payload mux.
    always_comb begin
        rr_take_s      = ~(|stream_elig_s) & (|rr_win_s);
        win_s          = (|stream_elig_s) ? stream_win_s : rr_win_s;
        pending_next_s = packet_slot ? (pending_r & ~win_s) : pending_r;
        pending_next_s = frame_start ? (pending_next_s | FRAME_MASK) : pending_next_s;
        win_hdr_s      = NULL_HEADER;
        win_sub_s      = NULL_SUB;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            win_hdr_s = win_hdr_s | (src_header[i] & {24{win_s[i]}});
            win_sub_s = win_sub_s | (src_sub[i] & {224{win_s[i]}});
        end
    end

    // Pending flags, round-robin pointer and sticky missed-frame flag.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            pending_r <= {NUM_SOURCES{1'b0}};
            ptr_r     <= RESET_PTR;
            missed_r  <= 1'b0;
        end else begin
            pending_r <= pending_next_s;
            if (packet_slot && rr_take_s) begin
                ptr_r <= rr_next_ptr_s;
            end else begin
                ptr_r <= ptr_r;
            end
            missed_r <= missed_r | (frame_start & (|pending_r));
        end
    end

    // Registered packet outputs: captured on packet_slot and held until the next one.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            header <= NULL_HEADER;
            sub    <= NULL_SUB;
            grant  <= {NUM_SOURCES{1'b0}};
        end else if (packet_slot) begin
            header <= win_hdr_s;
            sub    <= win_sub_s;
            grant  <= win_s;
        end else begin
            header <= header;
            sub    <= sub;
            grant  <= {NUM_SOURCES{1'b0}};
        end
    end

    assign pending      = pending_r;
    assign missed_frame = missed_r;

endmodule

// File: tb/tb_packet_scheduler.sv
// Directed, table-driven bench for packet_scheduler with hand-computed expectations.
module tb_packet_scheduler;
    import hdmi_packet_pkg::*;

    localparam int N = 5;

    logic           clk_pixel;
    logic           reset;
    logic           frame_start;
    logic [N-1:0]   req;
    header_t        src_header [N];
    sub_t           src_sub    [N];
    logic           packet_slot;
    header_t        header;
    sub_t           sub;
    logic [N-1:0]   grant;
    logic [N-1:0]   pending;
    logic           missed_frame;

    int n_cmp;
    int n_bad;

    packet_scheduler #(.NUM_SOURCES(N), .FRAME_MASK(5'b11100)) dut (
        .clk_pixel    (clk_pixel),
        .reset        (reset),
        .frame_start  (frame_start),
        .req          (req),
        .src_header   (src_header),
        .src_sub      (src_sub),
        .packet_slot  (packet_slot),
        .header       (header),
        .sub          (sub),
        .grant        (grant),
        .pending      (pending),
        .missed_frame (missed_frame)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        logic         fs;
        logic [N-1:0] rq;
        logic         slot;
        logic [N-1:0] g;
        logic [N-1:0] p;
        logic         m;
    } vec_t;

    vec_t vecs [$];

    function automatic header_t hdr_of(input int i);
        logic [7:0] c;
        case (i)
            0:       c = PKT_ACR;
            1:       c = PKT_AUDIO_SAMPLE;
            2:       c = PKT_AVI;
            3:       c = PKT_AUDIO_IF;
            4:       c = PKT_SPD;
            default: c = 8'h00;
        endcase
        return {8'(8'hA0 + i), 8'h5A, c};
    endfunction

    function automatic sub_t sub_of(input int i);
        sub_t s;
        for (int k = 0; k < 4; k++) begin
            s[k] = {48'hC0FFEE123400, 8'(i * 4 + k)};
        end
        return s;
    endfunction

    function automatic int idx_of(input logic [N-1:0] oh);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) r = i;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [223:0] act, input logic [223:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic fs, input logic [N-1:0] rq, input logic slot,
                       input logic [N-1:0] g, input logic [N-1:0] p, input logic m);
        vec_t v;
        v.fs = fs; v.rq = rq; v.slot = slot; v.g = g; v.p = p; v.m = m;
        vecs.push_back(v);
    endtask

    initial begin
        header_t exp_hdr;
        sub_t    exp_sub;
        int      w;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        frame_start = 1'b0;
        req = '0;
        packet_slot = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_header[i] = hdr_of(i);
            src_sub[i]    = sub_of(i);
        end

        // 1: idle slots give the null packet
        for (int i = 0; i < 5; i++) add(1'b0, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0);
        // 2: one frame of InfoFrames, round-robin from source 2
        add(1'b1, 5'b00000, 1'b0, 5'b00000, 5'b11100, 1'b0);
        add(1'b0, 5'b00000, 1'b1, 5'b00100, 5'b11000, 1'b0);
        add(1'b0, 5'b00000, 1'b1, 5'b01000, 5'b10000, 1'b0);
        add(1'b0, 5'b00000, 1'b1, 5'b10000, 5'b00000, 1'b0);
        add(1'b0, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0);
        // 3: streaming priority over frame sources
        add(1'b1, 5'b00011, 1'b0, 5'b00000, 5'b11100, 1'b0);
        add(1'b0, 5'b00011, 1'b1, 5'b00001, 5'b11100, 1'b0);
        add(1'b0, 5'b00011, 1'b1, 5'b00001, 5'b11100, 1'b0);
        add(1'b0, 5'b00010, 1'b1, 5'b00010, 5'b11100, 1'b0);
        add(1'b0, 5'b00000, 1'b1, 5'b00100, 5'b11000, 1'b0);
        add(1'b0, 5'b00000, 1'b0, 5'b00000, 5'b11000, 1'b0);
        add(1'b0, 5'b00000, 1'b1, 5'b01000, 5'b10000, 1'b0);
        add(1'b0, 5'b00000, 1'b1, 5'b10000, 5'b00000, 1'b0);
        // 4: starvation by req[0] across a frame sets missed_frame
        add(1'b1, 5'b00001, 1'b0, 5'b00000, 5'b11100, 1'b0);
        for (int i = 0; i < 3; i++) add(1'b0, 5'b00001, 1'b1, 5'b00001, 5'b11100, 1'b0);
        add(1'b1, 5'b00001, 1'b0, 5'b00000, 5'b11100, 1'b1);
        add(1'b0, 5'b00000, 1'b1, 5'b00100, 5'b11000, 1'b1);
        add(1'b0, 5'b00000, 1'b1, 5'b01000, 5'b10000, 1'b1);
        // 5: frame_start coinciding with the slot that grants source 4
        add(1'b1, 5'b00000, 1'b1, 5'b10000, 5'b11100, 1'b1);
        add(1'b0, 5'b00000, 1'b0, 5'b00000, 5'b11100, 1'b1);
        add(1'b0, 5'b00000, 1'b1, 5'b00100, 5'b11000, 1'b1);

        repeat (3) @(posedge clk_pixel);
        #1;
        check("rst_header", 224'(header), 224'(NULL_HEADER));
        check("rst_sub", 224'(sub), 224'(NULL_SUB));
        check("rst_grant", 224'(grant), 224'(5'b00000));
        check("rst_pending", 224'(pending), 224'(5'b00000));
        check("rst_missed", 224'(missed_frame), 224'(1'b0));
        @(negedge clk_pixel);
        reset = 1'b0;

        exp_hdr = NULL_HEADER;
        exp_sub = NULL_SUB;
        foreach (vecs[i]) begin
            @(negedge clk_pixel);
            frame_start = vecs[i].fs;
            req         = vecs[i].rq;
            packet_slot = vecs[i].slot;
            @(posedge clk_pixel);
            #1;
            if (vecs[i].slot) begin
                w = idx_of(vecs[i].g);
                exp_hdr = (w < 0) ? NULL_HEADER : hdr_of(w);
                exp_sub = (w < 0) ? NULL_SUB : sub_of(w);
            end
            check($sformatf("v%0d_grant", i), 224'(grant), 224'(vecs[i].g));
            check($sformatf("v%0d_pending", i), 224'(pending), 224'(vecs[i].p));
            check($sformatf("v%0d_missed", i), 224'(missed_frame), 224'(vecs[i].m));
            check($sformatf("v%0d_header", i), 224'(header), 224'(exp_hdr));
            check($sformatf("v%0d_sub", i), 224'(sub), 224'(exp_sub));
        end

        // 6: asynchronous reset right after the AVI grant
        @(negedge clk_pixel);
        frame_start = 1'b0;
        req         = '0;
        packet_slot = 1'b0;
        check("pre_rst_header", 224'(header), 224'(hdr_of(2)));
        reset = 1'b1;
        #1;
        check("arst_header", 224'(header), 224'(NULL_HEADER));
        check("arst_sub", 224'(sub), 224'(NULL_SUB));
        check("arst_pending", 224'(pending), 224'(5'b00000));
        check("arst_missed", 224'(missed_frame), 224'(1'b0));
        repeat (2) @(negedge clk_pixel);
        reset = 1'b0;
        @(negedge clk_pixel);
        frame_start = 1'b1;
        @(negedge clk_pixel);
        frame_start = 1'b0;
        packet_slot = 1'b1;
        @(posedge clk_pixel);
        #1;
        check("post_rst_grant", 224'(grant), 224'(5'b00100));
        check("post_rst_header", 224'(header), 224'(hdr_of(2)));
        check("post_rst_pending", 224'(pending), 224'(5'b11000));

        // Source changes its inputs after its grant: packet in flight must hold
        @(negedge clk_pixel);
        packet_slot   = 1'b0;
        src_header[2] = 24'hDEAD00;
        src_sub[2]    = NULL_SUB;
        @(posedge clk_pixel);
        #1;
        check("hold_header", 224'(header), 224'(hdr_of(2)));
        check("hold_sub", 224'(sub), 224'(sub_of(2)));
        check("hold_grant", 224'(grant), 224'(5'b00000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
